// File: rtl/operand_regs_if.sv
// rtl/operand_regs_if.sv - control, bus and result signals between sequencer and operand_regs
interface operand_regs_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] bus_in;
   logic             LoadA;
   logic             LoadB;
   logic             WriteBackA;
   logic             AOut;
   logic [1:0]       OpSelect;
   logic [WIDTH-1:0] ALUResults;
   logic [WIDTH-1:0] RegA;
   logic [WIDTH-1:0] RegB;
   logic [WIDTH-1:0] data_out;
   logic             FlagZ;
   logic             FlagC;
   logic             FlagN;

   modport master (
      output bus_in, LoadA, LoadB, WriteBackA, AOut, OpSelect, ALUResults,
      input  RegA, RegB, data_out, FlagZ, FlagC, FlagN
   );

   modport slave (
      input  bus_in, LoadA, LoadB, WriteBackA, AOut, OpSelect, ALUResults,
      output RegA, RegB, data_out, FlagZ, FlagC, FlagN
   );
endinterface

// File: rtl/operand_regs.sv
// rtl/operand_regs.sv - A/B operand registers with ALU write-back and Z/C/N status flags
// Carry is recomputed here from the pre-edge A/B rather than taken from the ALU.
module operand_regs #(
   parameter int WIDTH = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   operand_regs_if.slave bus
);
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             z_q, z_d;
   logic             c_q, c_d;
   logic             n_q, n_d;
   logic [WIDTH:0]   sum;

   assign sum = {1'b0, a_q} + {1'b0, b_q};

   always_comb begin
      a_d = a_q;
      b_d = b_q;
      z_d = z_q;
      c_d = c_q;
      n_d = n_q;
      // Write-back outranks LoadA; flags move only with write-back.
      if (bus.WriteBackA) begin
         a_d = bus.ALUResults;
         z_d = (bus.ALUResults == '0);
         n_d = bus.ALUResults[WIDTH-1];
         case (bus.OpSelect)
            2'b00:   c_d = sum[WIDTH];
            2'b01:   c_d = (a_q < b_q);
            default: c_d = 1'b0;
         endcase
      end else if (bus.LoadA) begin
         a_d = bus.bus_in;
      end
      if (bus.LoadB) begin
         b_d = bus.bus_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q <= '0;
         b_q <= '0;
         z_q <= 1'b0;
         c_q <= 1'b0;
         n_q <= 1'b0;
      end else begin
         a_q <= a_d;
         b_q <= b_d;
         z_q <= z_d;
         c_q <= c_d;
         n_q <= n_d;
      end
   end

   assign bus.RegA     = a_q;
   assign bus.RegB     = b_q;
   assign bus.FlagZ    = z_q;
   assign bus.FlagC    = c_q;
   assign bus.FlagN    = n_q;
   assign bus.data_out = bus.AOut ? a_q : '0;
endmodule

// File: tb/tb_operand_regs.sv
// tb/tb_operand_regs.sv - directed vector bench for operand_regs
module tb_operand_regs;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   operand_regs_if #(.WIDTH(8)) bus_if ();

   operand_regs #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       la;
      logic       lb;
      logic       wb;
      logic       ao;
      logic [1:0] op;
      logic [7:0] bus;
      logic [7:0] alu;
      logic [7:0] ea;
      logic [7:0] eb;
      logic       ez;
      logic       ec;
      logic       en;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic check_state(input string tag, input logic [7:0] ea, input logic [7:0] eb,
                              input logic ez, input logic ec, input logic en);
      check({tag, " RegA"},  {8'h00, bus_if.RegA}, {8'h00, ea});
      check({tag, " RegB"},  {8'h00, bus_if.RegB}, {8'h00, eb});
      check({tag, " flags"}, {13'h0, bus_if.FlagZ, bus_if.FlagC, bus_if.FlagN}, {13'h0, ez, ec, en});
   endtask

   task automatic drive(input logic la, input logic lb, input logic wb, input logic ao,
                        input logic [1:0] op, input logic [7:0] bv, input logic [7:0] alu);
      bus_if.LoadA      = la;
      bus_if.LoadB      = lb;
      bus_if.WriteBackA = wb;
      bus_if.AOut       = ao;
      bus_if.OpSelect   = op;
      bus_if.bus_in     = bv;
      bus_if.ALUResults = alu;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 8'h00, 8'h00);

      //            la    lb    wb    ao    op     bus    alu    ea     eb     z     c     n
      vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 8'h28, 8'h00, 8'h28, 8'h00, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 8'h1E, 8'h00, 8'h28, 8'h1E, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 8'h00, 8'h46, 8'h46, 8'h1E, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 8'hF0, 8'h00, 8'hF0, 8'h1E, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 8'h20, 8'h00, 8'hF0, 8'h20, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 8'h00, 8'h10, 8'h10, 8'h20, 1'b0, 1'b1, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 8'h05, 8'h00, 8'h05, 8'h20, 1'b0, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 8'h07, 8'h00, 8'h05, 8'h07, 1'b0, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 8'h00, 8'hFE, 8'hFE, 8'h07, 1'b0, 1'b1, 1'b1});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 8'h07, 8'h00, 8'h07, 8'h07, 1'b0, 1'b1, 1'b1});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 8'h00, 8'h00, 8'h00, 8'h07, 1'b1, 1'b0, 1'b0});
      // Collision: write-back beats LoadA, B still loads, flags follow ALUResults.
      vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 8'hAA, 8'h33, 8'h33, 8'hAA, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 8'h00, 8'hFF, 8'h33, 8'hAA, 1'b0, 1'b0, 1'b0});
      // Held write-back: FF+1 wraps with carry and zero, then increments again.
      vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 8'hFF, 8'h00, 8'hFF, 8'hAA, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 8'h01, 8'h00, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 8'h00, 8'h00, 8'h00, 8'h01, 1'b1, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 8'h00, 8'h01, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0});
      // Write-back with LoadB: borrow judged against old B=01, not new B=05.
      vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 8'h02, 8'h00, 8'h02, 8'h01, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 8'h05, 8'h01, 8'h01, 8'h05, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 8'h00, 8'hFC, 8'hFC, 8'h05, 1'b0, 1'b1, 1'b1});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 8'h00, 8'h80, 8'h80, 8'h05, 1'b0, 1'b0, 1'b1});

      #1;
      check_state("reset", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      check("reset data_out", {8'h00, bus_if.data_out}, 16'h0000);

      // Load strobe during reset must not capture.
      drive(1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 8'h77, 8'h77);
      @(posedge clk); #1;
      check_state("reset-load", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00);

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i].la, vecs[i].lb, vecs[i].wb, vecs[i].ao, vecs[i].op, vecs[i].bus, vecs[i].alu);
         @(posedge clk); #1;
         check_state($sformatf("vec%0d", i), vecs[i].ea, vecs[i].eb, vecs[i].ez, vecs[i].ec, vecs[i].en);
         check($sformatf("vec%0d data_out", i), {8'h00, bus_if.data_out},
               {8'h00, (vecs[i].ao ? vecs[i].ea : 8'h00)});
      end

      // Bus drive: data_out follows AOut with no clock edge.
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 8'h9C, 8'h00);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 8'h00, 8'h00);
      #1 check("aout1 data_out", {8'h00, bus_if.data_out}, 16'h009C);
      bus_if.AOut = 1'b0;
      #1 check("aout0 data_out", {8'h00, bus_if.data_out}, 16'h0000);
      bus_if.AOut = 1'b1;
      #1 check("aout1b data_out", {8'h00, bus_if.data_out}, 16'h009C);
      check("aout RegA", {8'h00, bus_if.RegA}, 16'h009C);

      // Reset mid-operation, asserted between edges.
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 8'h55, 8'h00);
      @(posedge clk); #1;
      check("pre-reset RegA", {8'h00, bus_if.RegA}, 16'h0055);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 8'h00, 8'h00);
      @(posedge clk); #1;
      check("pre-reset FlagZ", {15'h0, bus_if.FlagZ}, 16'h0001);
      #2 rst_n = 1'b0;
      #1;
      check_state("async reset", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      check("async reset data_out", {8'h00, bus_if.data_out}, 16'h0000);

      // First edge after release performs a load.
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 8'h3C, 8'h00);
      @(posedge clk); #1;
      check("release load RegA", {8'h00, bus_if.RegA}, 16'h003C);
      check("release data_out", {8'h00, bus_if.data_out}, 16'h003C);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
